pwm_ramp_ctrl: RTL and testbench

//  Duty-cycle sequencer for one pwm_core channel: breathing/fade ramps lo->hi->lo with dwell.

---
 rtl/pwm_ctrl_pkg.sv | 24 ++
 rtl/pwm_ramp_ctrl.sv | 149 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types for the pwm channel controllers.
// Default widths, ramp FSM states and the latched ramp config.
package pwm_ctrl_pkg;

   localparam int unsigned DefDutyDw = 16;
   localparam int unsigned DefHoldDw = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAMP_UP,
      ST_HOLD_HI,
      ST_RAMP_DOWN,
      ST_HOLD_LO
   } ramp_state_e;

   typedef struct packed {
      logic [DefDutyDw-1:0] lo;
      logic [DefDutyDw-1:0] hi;
      logic [DefDutyDw-1:0] step;
      logic [DefHoldDw-1:0] hold;
      logic                 oneshot;
   } ramp_cfg_t;

endpackage

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer for one pwm_core channel.
// Breathing lo->hi->lo with dwell, one step per PWM period.
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned DutyDw = DefDutyDw,
   parameter int unsigned HoldDw = DefHoldDw
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic [DutyDw-1:0] cfg_lo_i,
   input  logic [DutyDw-1:0] cfg_hi_i,
   input  logic [DutyDw-1:0] cfg_step_i,
   input  logic [HoldDw-1:0] cfg_hold_i,
   input  logic              cfg_oneshot_i,
   input  logic              cycle_end_i,
   output logic [DutyDw-1:0] duty_o,
   output logic              duty_upd_o,
   output logic              busy_o,
   output logic              done_o
);

   ramp_state_e       state_q, state_d;
   ramp_cfg_t         cfg_q, cfg_d;
   logic [DutyDw-1:0] duty_q, duty_d;
   logic [HoldDw-1:0] hold_q, hold_d;
   logic              upd_q, upd_d;
   logic              done_q, done_d;

   logic [DutyDw:0]   sum_up;
   logic [DutyDw:0]   lo_plus;
   logic [DutyDw-1:0] up_nxt;
   logic [DutyDw-1:0] dn_nxt;
   logic [DutyDw-1:0] hi_clamp;
   logic              hold_done;

   // Extra carry bit keeps near-max bounds from wrapping.
   assign sum_up  = {1'b0, duty_q} + {1'b0, cfg_q.step};
   assign lo_plus = {1'b0, cfg_q.lo} + {1'b0, cfg_q.step};

   assign up_nxt = (cfg_q.step == '0 || sum_up >= {1'b0, cfg_q.hi})
                 ? cfg_q.hi : sum_up[DutyDw-1:0];
   assign dn_nxt = (cfg_q.step == '0 || {1'b0, duty_q} < lo_plus)
                 ? cfg_q.lo : duty_q - cfg_q.step;

   assign hi_clamp  = (cfg_hi_i < cfg_lo_i) ? cfg_lo_i : cfg_hi_i;
   assign hold_done = (hold_q == cfg_q.hold);

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (en_i) begin
               cfg_d.lo      = cfg_lo_i;
               cfg_d.hi      = hi_clamp;
               cfg_d.step    = cfg_step_i;
               cfg_d.hold    = cfg_hold_i;
               cfg_d.oneshot = cfg_oneshot_i;
               duty_d        = cfg_lo_i;
               hold_d        = '0;
               state_d       = ST_RAMP_UP;
            end
         end
         ST_RAMP_UP: begin
            if (cycle_end_i) begin
               duty_d = up_nxt;
               if (up_nxt == cfg_q.hi) begin
                  state_d = ST_HOLD_HI;
                  hold_d  = '0;
               end
            end
         end
         ST_HOLD_HI: begin
            if (cycle_end_i) begin
               if (hold_done) begin
                  duty_d  = dn_nxt;
                  hold_d  = '0;
                  state_d = (dn_nxt == cfg_q.lo)
                          ? ST_HOLD_LO : ST_RAMP_DOWN;
               end else begin
                  hold_d = hold_q + HoldDw'(1);
               end
            end
         end
         ST_RAMP_DOWN: begin
            if (cycle_end_i) begin
               duty_d = dn_nxt;
               if (dn_nxt == cfg_q.lo) begin
                  state_d = ST_HOLD_LO;
                  hold_d  = '0;
               end
            end
         end
         ST_HOLD_LO: begin
            if (cycle_end_i) begin
               if (!hold_done) begin
                  hold_d = hold_q + HoldDw'(1);
               end else if (cfg_q.oneshot) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  duty_d  = up_nxt;
                  hold_d  = '0;
                  state_d = (up_nxt == cfg_q.hi)
                          ? ST_HOLD_HI : ST_RAMP_UP;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort overrides any simultaneous period event.
      if (state_q != ST_IDLE && !en_i) begin
         state_d = ST_IDLE;
         duty_d  = '0;
         hold_d  = '0;
         done_d  = 1'b0;
      end
      upd_d = (duty_d != duty_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cfg_q   <= '0;
         duty_q  <= '0;
         hold_q  <= '0;
         upd_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         duty_q  <= duty_d;
         hold_q  <= hold_d;
         upd_q   <= upd_d;
         done_q  <= done_d;
      end
   end

   assign duty_o     = duty_q;
   assign duty_upd_o = upd_q;
   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl.
// Expected outputs queue per clock and are popped after the edge.
module tb_pwm_ramp_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        en_i = 1'b0;
   logic [15:0] cfg_lo_i = '0;
   logic [15:0] cfg_hi_i = '0;
   logic [15:0] cfg_step_i = '0;
   logic [7:0]  cfg_hold_i = '0;
   logic        cfg_oneshot_i = 1'b0;
   logic        cycle_end_i = 1'b0;
   logic [15:0] duty_o;
   logic        duty_upd_o;
   logic        busy_o;
   logic        done_o;

   pwm_ramp_ctrl dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .en_i          (en_i),
      .cfg_lo_i      (cfg_lo_i),
      .cfg_hi_i      (cfg_hi_i),
      .cfg_step_i    (cfg_step_i),
      .cfg_hold_i    (cfg_hold_i),
      .cfg_oneshot_i (cfg_oneshot_i),
      .cycle_end_i   (cycle_end_i),
      .duty_o        (duty_o),
      .duty_upd_o    (duty_upd_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int duty;
      bit upd;
      bit busy;
      bit done;
   } exp_t;

   exp_t sbq[$];
   int   prev_duty = 0;
   int   checks = 0;
   int   errors = 0;

   int m_lo, m_hi, m_step, m_hold, m_os;
   int m_duty, m_cnt, m_st;

   int t1 [8] = '{20, 30, 40, 40, 30, 20, 10, 10};

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, expv);
      end
   endtask

   task automatic push(input int d, input bit b, input bit dn);
      exp_t e;
      e.duty = d;
      e.upd  = (d != prev_duty);
      e.busy = b;
      e.done = dn;
      prev_duty = d;
      sbq.push_back(e);
   endtask

   task automatic tick(input logic ce, input string tag);
      exp_t e;
      cycle_end_i = ce;
      @(posedge clk_i);
      @(negedge clk_i);
      cycle_end_i = 1'b0;
      if (sbq.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sbq.pop_front();
         chk({tag, ".duty"}, 32'(duty_o), e.duty);
         chk({tag, ".upd"}, 32'(duty_upd_o), 32'(e.upd));
         chk({tag, ".busy"}, 32'(busy_o), 32'(e.busy));
         chk({tag, ".done"}, 32'(done_o), 32'(e.done));
      end
   endtask

   task automatic set_cfg(input int lo, input int hi,
                          input int st, input int hd,
                          input bit os);
      cfg_lo_i      = 16'(lo);
      cfg_hi_i      = 16'(hi);
      cfg_step_i    = 16'(st);
      cfg_hold_i    = 8'(hd);
      cfg_oneshot_i = os;
   endtask

   function automatic int m_up();
      int n;
      n = m_duty + m_step;
      if (m_step == 0 || n > m_hi) n = m_hi;
      return n;
   endfunction

   function automatic int m_dn();
      int n;
      n = m_duty - m_step;
      if (m_step == 0 || n < m_lo) n = m_lo;
      return n;
   endfunction

   task automatic m_start();
      m_lo   = int'(cfg_lo_i);
      m_hi   = (cfg_hi_i < cfg_lo_i) ? int'(cfg_lo_i)
                                     : int'(cfg_hi_i);
      m_step = int'(cfg_step_i);
      m_hold = int'(cfg_hold_i);
      m_os   = int'(cfg_oneshot_i);
      m_duty = m_lo;
      m_cnt  = 0;
      m_st   = 1;
      push(m_duty, 1'b1, 1'b0);
   endtask

   task automatic m_event();
      bit dn;
      dn = 1'b0;
      case (m_st)
         1: begin
            m_duty = m_up();
            if (m_duty == m_hi) begin m_st = 2; m_cnt = 0; end
         end
         2: begin
            if (m_cnt < m_hold) m_cnt++;
            else begin
               m_duty = m_dn();
               m_cnt  = 0;
               m_st   = (m_duty == m_lo) ? 4 : 3;
            end
         end
         3: begin
            m_duty = m_dn();
            if (m_duty == m_lo) begin m_st = 4; m_cnt = 0; end
         end
         4: begin
            if (m_cnt < m_hold) m_cnt++;
            else if (m_os != 0) begin m_st = 0; dn = 1'b1; end
            else begin
               m_duty = m_up();
               m_cnt  = 0;
               m_st   = (m_duty == m_hi) ? 2 : 1;
            end
         end
         default: ;
      endcase
      push(m_duty, m_st != 0, dn);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst.duty", 32'(duty_o), 32'd0);
      chk("rst.upd", 32'(duty_upd_o), 32'd0);
      chk("rst.busy", 32'(busy_o), 32'd0);
      chk("rst.done", 32'(done_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // 1: oneshot breathing pass
      set_cfg(10, 40, 10, 1, 1'b1);
      en_i = 1'b1;
      push(10, 1'b1, 1'b0);
      tick(1'b0, "t1.start");
      foreach (t1[i]) begin
         push(t1[i], 1'b1, 1'b0);
         tick(1'b1, "t1.ev");
      end
      push(10, 1'b0, 1'b1);
      tick(1'b1, "t1.done");
      en_i = 1'b0;
      push(10, 1'b0, 1'b0);
      tick(1'b1, "idle_ce");

      // 2: continuous, period of 8 events
      set_cfg(10, 40, 10, 1, 1'b0);
      en_i = 1'b1;
      push(10, 1'b1, 1'b0);
      tick(1'b0, "t2.start");
      for (int i = 0; i < 16; i++) begin
         push(t1[i % 8], 1'b1, 1'b0);
         tick(1'b1, "t2.ev");
      end
      en_i = 1'b0;
      push(0, 1'b0, 1'b0);
      tick(1'b0, "t2.stop");

      // 3a: saturate at hi
      set_cfg(0, 25, 10, 0, 1'b1);
      en_i = 1'b1;
      push(0, 1'b1, 1'b0);
      tick(1'b0, "t3a.start");
      push(10, 1'b1, 1'b0); tick(1'b1, "t3a.ev");
      push(20, 1'b1, 1'b0); tick(1'b1, "t3a.ev");
      push(25, 1'b1, 1'b0); tick(1'b1, "t3a.ev");
      en_i = 1'b0;
      push(0, 1'b0, 1'b0);
      tick(1'b0, "t3a.stop");

      // 3b: step 0 jumps, then restart with en held
      set_cfg(5, 200, 0, 0, 1'b1);
      en_i = 1'b1;
      push(5, 1'b1, 1'b0);
      tick(1'b0, "t3b.start");
      push(200, 1'b1, 1'b0); tick(1'b1, "t3b.ev");
      push(5, 1'b1, 1'b0);   tick(1'b1, "t3b.ev");
      push(5, 1'b0, 1'b1);   tick(1'b1, "t3b.done");
      push(5, 1'b1, 1'b0);   tick(1'b0, "t3b.restart");
      en_i = 1'b0;
      push(0, 1'b0, 1'b0);
      tick(1'b0, "t3b.stop");

      // 3c: hi below lo clamps to lo
      set_cfg(7, 3, 2, 0, 1'b0);
      en_i = 1'b1;
      push(7, 1'b1, 1'b0);
      tick(1'b0, "t3c.start");
      for (int i = 0; i < 4; i++) begin
         push(7, 1'b1, 1'b0);
         tick(1'b1, "t3c.ev");
      end
      en_i = 1'b0;
      push(0, 1'b0, 1'b0);
      tick(1'b0, "t3c.stop");

      // 3d: near-max bounds, no wrap
      set_cfg(16'hFFF0, 16'hFFFF, 16'h20, 0, 1'b1);
      en_i = 1'b1;
      push(16'hFFF0, 1'b1, 1'b0);
      tick(1'b0, "t3d.start");
      push(16'hFFFF, 1'b1, 1'b0); tick(1'b1, "t3d.ev");
      push(16'hFFF0, 1'b1, 1'b0); tick(1'b1, "t3d.ev");
      push(16'hFFF0, 1'b0, 1'b1); tick(1'b1, "t3d.done");
      en_i = 1'b0;
      push(16'hFFF0, 1'b0, 1'b0);
      tick(1'b0, "t3d.idle");

      // 4: abort in RAMP_DOWN with coincident cycle_end
      set_cfg(10, 40, 10, 1, 1'b1);
      en_i = 1'b1;
      push(10, 1'b1, 1'b0);
      tick(1'b0, "t4.start");
      for (int i = 0; i < 5; i++) begin
         push(t1[i], 1'b1, 1'b0);
         tick(1'b1, "t4.ev");
      end
      en_i = 1'b0;
      push(0, 1'b0, 1'b0);
      tick(1'b1, "t4.abort");

      // 5: async reset mid-HOLD_HI
      set_cfg(10, 40, 10, 3, 1'b1);
      en_i = 1'b1;
      push(10, 1'b1, 1'b0);
      tick(1'b0, "t5.start");
      push(20, 1'b1, 1'b0); tick(1'b1, "t5.ev");
      push(30, 1'b1, 1'b0); tick(1'b1, "t5.ev");
      push(40, 1'b1, 1'b0); tick(1'b1, "t5.ev");
      push(40, 1'b1, 1'b0); tick(1'b1, "t5.ev");
      #2 rst_ni = 1'b0;
      #1;
      chk("t5.rst.duty", 32'(duty_o), 32'd0);
      chk("t5.rst.upd", 32'(duty_upd_o), 32'd0);
      chk("t5.rst.busy", 32'(busy_o), 32'd0);
      chk("t5.rst.done", 32'(done_o), 32'd0);
      prev_duty = 0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      push(10, 1'b1, 1'b0);
      tick(1'b0, "t5.restart");
      en_i = 1'b0;
      push(0, 1'b0, 1'b0);
      tick(1'b0, "t5.stop");

      // 6: cfg changes mid-ramp are ignored until restart
      set_cfg(100, 400, 50, 2, 1'b0);
      en_i = 1'b1;
      m_start();
      tick(1'b0, "t6.start");
      for (int i = 0; i < 3; i++) begin
         m_event();
         tick(1'b1, "t6.ev");
      end
      set_cfg(0, 150, 7, 2, 1'b0);
      for (int i = 0; i < 20; i++) begin
         m_event();
         tick(1'b1, "t6.ev");
      end
      en_i = 1'b0;
      m_st = 0;
      push(0, 1'b0, 1'b0);
      tick(1'b0, "t6.stop");
      en_i = 1'b1;
      m_start();
      tick(1'b0, "t6.restart");
      for (int i = 0; i < 25; i++) begin
         m_event();
         tick(1'b1, "t6.ev2");
      end
      en_i = 1'b0;
      push(0, 1'b0, 1'b0);
      tick(1'b0, "t6.end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
